// File: rtl/chess_pkg.sv
// Shared piece encodings and helpers for the chess board store.
// A square code is {colour, piece}; colour 1 means black.
package chess_pkg;
    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    typedef enum logic {ST_IDLE, ST_INIT} board_state_e;

    // Back-rank layout R N B Q K B N R, indexed by file.
    function automatic logic [2:0] back_rank_piece(input int f);
        case (f)
            0, 7:    return PIECE_ROOK;
            1, 6:    return PIECE_KNIGHT;
            2, 5:    return PIECE_BISHOP;
            3:       return PIECE_QUEEN;
            4:       return PIECE_KING;
            default: return PIECE_NONE;
        endcase
    endfunction

    // History entry holds {from, to, old[from], old[to]}.
    function automatic int hist_entry_w(input int aw, input int pw);
        return 2 * aw + 2 * pw;
    endfunction
endpackage

// File: rtl/chess_hist_stack.sv
// Circular undo stack: pushes overwrite the oldest entry once full,
// the count saturates at HIST_DEPTH, and top_o is the last pushed entry.
module chess_hist_stack #(
    parameter int HIST_DEPTH = 16,
    parameter int ENTRY_W    = 8
) (
    input  logic                          full_clock,
    input  logic                          Reset,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [ENTRY_W-1:0]            push_data_i,
    output logic [ENTRY_W-1:0]            top_o,
    output logic [$clog2(HIST_DEPTH):0]   count_o
);
    localparam int PW = $clog2(HIST_DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem_q [HIST_DEPTH];
    logic [PW-1:0]      ptr_q;
    logic [CW-1:0]      cnt_q;

    always_ff @(posedge full_clock) begin
        if (push_i) mem_q[ptr_q] <= push_data_i;
    end

    // ptr_q is the next free slot; the count alone decides emptiness.
    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_q + 1'b1;
            if (cnt_q != CW'(HIST_DEPTH)) cnt_q <= cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            ptr_q <= ptr_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign top_o   = mem_q[ptr_q - 1'b1];
    assign count_o = cnt_q;
endmodule

// File: rtl/chess_board_store.sv
// Board-state store: initial-position load, checked two-square moves,
// undo history, registered read port and a flattened board view.
module chess_board_store
    import chess_pkg::*;
#(
    parameter int FILES      = 8,
    parameter int RANKS      = 8,
    parameter int PIECE_W    = 4,
    parameter int HIST_DEPTH = 16,
    parameter int DIV_BITS   = 12,
    localparam int AW        = $clog2(RANKS) + $clog2(FILES)
) (
    input  logic                            full_clock,
    input  logic                            Reset,
    output logic                            tick,
    input  logic                            init_req,
    output logic                            init_done,
    input  logic                            move_valid,
    output logic                            move_ready,
    input  logic [AW-1:0]                   move_from,
    input  logic [AW-1:0]                   move_to,
    input  logic [PIECE_W-1:0]              move_piece,
    input  logic                            undo_req,
    output logic                            cmd_err,
    input  logic [AW-1:0]                   rd_addr,
    output logic [PIECE_W-1:0]              rd_piece,
    output logic [FILES*RANKS*PIECE_W-1:0]  board_flat,
    output logic [$clog2(HIST_DEPTH):0]     hist_count
);
    localparam int FW  = $clog2(FILES);
    localparam int RW  = $clog2(RANKS);
    localparam int NSQ = FILES * RANKS;
    localparam int EW  = hist_entry_w(AW, PIECE_W);

    board_state_e         state_q, state_d;
    logic [RW-1:0]        rank_q, rank_d;
    logic                 init_done_q, init_done_d;
    logic                 cmd_err_q, err;
    logic                 do_move, do_undo, do_init;
    logic [DIV_BITS-1:0]  div_q;
    logic [PIECE_W-1:0]   board_q [NSQ];
    logic [PIECE_W-1:0]   rd_piece_q;
    logic [EW-1:0]        hist_top, push_data;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (int'(a[FW-1:0]) < FILES) && (int'(a[AW-1:FW]) < RANKS);
    endfunction

    // Out-of-range addresses map to square 0; callers gate the access.
    function automatic int sq_idx(input logic [AW-1:0] a);
        return in_range(a) ? int'(a[AW-1:FW]) * FILES + int'(a[FW-1:0]) : 0;
    endfunction

    function automatic logic [PIECE_W-1:0] start_piece(input int r, input int f);
        logic [PIECE_W-1:0] p;
        p = '0;
        if (r == 0 || r == RANKS - 1) p[2:0] = back_rank_piece(f);
        else if (r == 1 || r == RANKS - 2) p[2:0] = PIECE_PAWN;
        if (r <= 1) p[PIECE_W-1] = COLOR_BLACK;
        return p;
    endfunction

    always_comb begin
        state_d     = state_q;
        rank_d      = rank_q;
        init_done_d = init_done_q;
        do_move     = 1'b0;
        do_undo     = 1'b0;
        do_init     = 1'b0;
        err         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d     = ST_INIT;
                    rank_d      = '0;
                    do_init     = 1'b1;
                    init_done_d = 1'b0;
                end else if (undo_req) begin
                    init_done_d = 1'b0;
                    if (hist_count == '0) err = 1'b1;
                    else do_undo = 1'b1;
                end else if (move_valid) begin
                    init_done_d = 1'b0;
                    if (!in_range(move_from) || !in_range(move_to) || move_from == move_to)
                        err = 1'b1;
                    else
                        do_move = 1'b1;
                end
            end
            ST_INIT: begin
                rank_d = rank_q + 1'b1;
                if (int'(rank_q) == RANKS - 1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            rank_q      <= '0;
            init_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            rank_q      <= rank_d;
            init_done_q <= init_done_d;
            cmd_err_q   <= err;
            div_q       <= div_q + 1'b1;
        end
    end

    // rd_piece samples the board before this cycle's write lands.
    always_ff @(posedge full_clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NSQ; i++) board_q[i] <= '0;
            rd_piece_q <= '0;
        end else begin
            rd_piece_q <= in_range(rd_addr) ? board_q[sq_idx(rd_addr)] : '0;
            if (state_q == ST_INIT) begin
                for (int r = 0; r < RANKS; r++)
                    for (int f = 0; f < FILES; f++)
                        if (int'(rank_q) == r) board_q[r*FILES+f] <= start_piece(r, f);
            end else if (do_move) begin
                board_q[sq_idx(move_to)]   <= move_piece;
                board_q[sq_idx(move_from)] <= '0;
            end else if (do_undo) begin
                board_q[sq_idx(hist_top[EW-1 -: AW])]    <= hist_top[2*PIECE_W-1 -: PIECE_W];
                board_q[sq_idx(hist_top[EW-1-AW -: AW])] <= hist_top[PIECE_W-1:0];
            end
        end
    end

    assign push_data = {move_from, move_to, board_q[sq_idx(move_from)], board_q[sq_idx(move_to)]};

    chess_hist_stack #(
        .HIST_DEPTH (HIST_DEPTH),
        .ENTRY_W    (EW)
    ) u_hist (
        .full_clock  (full_clock),
        .Reset       (Reset),
        .clear_i     (do_init),
        .push_i      (do_move),
        .pop_i       (do_undo),
        .push_data_i (push_data),
        .top_o       (hist_top),
        .count_o     (hist_count)
    );

    for (genvar i = 0; i < NSQ; i++) begin : g_flat
        assign board_flat[i*PIECE_W +: PIECE_W] = board_q[i];
    end

    assign tick       = &div_q;
    assign move_ready = (state_q == ST_IDLE);
    assign init_done  = init_done_q;
    assign cmd_err    = cmd_err_q;
    assign rd_piece   = rd_piece_q;
endmodule

// File: tb/tb_chess_board_store.sv
// Directed bench for chess_board_store: an 8x8 instance for the main
// scenarios and a 6-file instance for range checking and addressing.
module tb_chess_board_store;
    logic full_clock = 1'b0;
    logic Reset;
    always #5 full_clock = ~full_clock;

    logic         tick, init_req, init_done, move_valid, move_ready, undo_req, cmd_err;
    logic [5:0]   move_from, move_to, rd_addr;
    logic [3:0]   move_piece, rd_piece;
    logic [255:0] board_flat;
    logic [4:0]   hist_count;

    logic         m_tick, m_init_req, m_init_done, m_move_valid, m_move_ready, m_undo_req, m_cmd_err;
    logic [5:0]   m_from, m_to, m_rd_addr;
    logic [3:0]   m_piece, m_rd_piece;
    logic [191:0] m_flat;
    logic [4:0]   m_hist;

    chess_board_store dut (
        .full_clock (full_clock), .Reset (Reset), .tick (tick),
        .init_req (init_req), .init_done (init_done),
        .move_valid (move_valid), .move_ready (move_ready),
        .move_from (move_from), .move_to (move_to), .move_piece (move_piece),
        .undo_req (undo_req), .cmd_err (cmd_err),
        .rd_addr (rd_addr), .rd_piece (rd_piece),
        .board_flat (board_flat), .hist_count (hist_count)
    );

    chess_board_store #(.FILES(6)) dut6 (
        .full_clock (full_clock), .Reset (Reset), .tick (m_tick),
        .init_req (m_init_req), .init_done (m_init_done),
        .move_valid (m_move_valid), .move_ready (m_move_ready),
        .move_from (m_from), .move_to (m_to), .move_piece (m_piece),
        .undo_req (m_undo_req), .cmd_err (m_cmd_err),
        .rd_addr (m_rd_addr), .rd_piece (m_rd_piece),
        .board_flat (m_flat), .hist_count (m_hist)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [3:0]   exp_b [64];
    logic [255:0] snap [17];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge full_clock);
        #1;
    endtask

    function automatic logic [3:0] sq(input int i);
        return board_flat[i*4 +: 4];
    endfunction

    function automatic logic [255:0] exp_flat();
        logic [255:0] v;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = exp_b[i];
        return v;
    endfunction

    task automatic load_model(input logic [255:0] v);
        for (int i = 0; i < 64; i++) exp_b[i] = v[i*4 +: 4];
    endtask

    task automatic set_init_model();
        logic [3:0] back [8];
        back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        for (int i = 0; i < 64; i++) exp_b[i] = 4'h0;
        for (int f = 0; f < 8; f++) begin
            exp_b[f]      = back[f] | 4'h8;
            exp_b[8 + f]  = 4'h9;
            exp_b[48 + f] = 4'h1;
            exp_b[56 + f] = back[f];
        end
    endtask

    task automatic do_move(input int from, input int to, input logic [3:0] pc);
        move_from = 6'(from); move_to = 6'(to); move_piece = pc; move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        exp_b[to] = pc;
        exp_b[from] = 4'h0;
    endtask

    task automatic do_undo();
        undo_req = 1'b1;
        step();
        undo_req = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (!move_ready && busy < 20) begin
            busy++;
            step();
        end
    endtask

    initial begin
        int busy, t0, t1;
        logic [255:0] pre;
        Reset = 1'b1;
        {init_req, move_valid, undo_req} = '0;
        move_from = '0; move_to = '0; move_piece = '0; rd_addr = '0;
        {m_init_req, m_move_valid, m_undo_req} = '0;
        m_from = '0; m_to = '0; m_piece = '0; m_rd_addr = '0;
        step(); step();
        Reset = 1'b0;
        step();
        check("rst_board", board_flat, '0);
        check("rst_hist", 256'(hist_count), 0);
        check("rst_init_done", 256'(init_done), 0);
        check("rst_cmd_err", 256'(cmd_err), 0);
        check("rst_rd_piece", 256'(rd_piece), 0);
        check("rst_ready", 256'(move_ready), 1);

        // Initial position load
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        wait_idle(busy);
        check("init_busy", 256'(busy), 8);
        check("init_sq0", 256'(sq(0)), 256'hC);
        check("init_sq60", 256'(sq(60)), 256'h6);
        check("init_sq20", 256'(sq(20)), 0);
        check("init_sq3", 256'(sq(3)), 256'hD);
        check("init_done", 256'(init_done), 1);
        set_init_model();
        check("init_board", board_flat, exp_flat());

        // Single move and undo
        do_move(52, 36, 4'h1);
        check("mv_sq36", 256'(sq(36)), 1);
        check("mv_sq52", 256'(sq(52)), 0);
        check("mv_hist", 256'(hist_count), 1);
        check("mv_init_done_clr", 256'(init_done), 0);
        do_undo();
        check("undo_sq52", 256'(sq(52)), 1);
        check("undo_sq36", 256'(sq(36)), 0);
        check("undo_hist", 256'(hist_count), 0);
        set_init_model();

        // 17 moves overflow the 16-entry history
        for (int k = 0; k < 17; k++) begin
            snap[k] = exp_flat();
            do_move(8 + k, 40 + (k % 8), {k[0], 3'(k % 6 + 1)});
        end
        check("ovf_board", board_flat, exp_flat());
        check("ovf_hist", 256'(hist_count), 16);
        for (int j = 1; j <= 16; j++) begin
            do_undo();
            check($sformatf("ovf_undo%0d", j), board_flat, snap[17 - j]);
        end
        check("ovf_hist_empty", 256'(hist_count), 0);
        do_undo();
        check("empty_undo_err", 256'(cmd_err), 1);
        check("empty_undo_board", board_flat, snap[1]);
        step();
        check("err_pulse_end", 256'(cmd_err), 0);
        load_model(snap[1]);

        // Simultaneous init/undo/move: init wins, held move lands afterwards
        do_move(20, 21, 4'h3);
        check("pre_init_hist", 256'(hist_count), 1);
        init_req = 1'b1; undo_req = 1'b1; move_valid = 1'b1;
        move_from = 6'd52; move_to = 6'd36; move_piece = 4'h1;
        step();
        init_req = 1'b0; undo_req = 1'b0;
        check("prio_hist_clr", 256'(hist_count), 0);
        check("prio_busy", 256'(move_ready), 0);
        wait_idle(busy);
        check("prio_init_busy", 256'(busy), 8);
        set_init_model();
        check("prio_init_board", board_flat, exp_flat());
        step();
        move_valid = 1'b0;
        exp_b[36] = 4'h1; exp_b[52] = 4'h0;
        check("held_move_board", board_flat, exp_flat());
        check("held_move_hist", 256'(hist_count), 1);

        // Rejected from==to, then read-during-write
        pre = exp_flat();
        move_from = 6'd36; move_to = 6'd36; move_piece = 4'h5; move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        check("same_sq_err", 256'(cmd_err), 1);
        check("same_sq_board", board_flat, pre);
        check("same_sq_hist", 256'(hist_count), 1);
        rd_addr = 6'd36;
        do_move(36, 28, 4'hA);
        check("rdw_old", 256'(rd_piece), 1);
        check("rdw_board", board_flat, exp_flat());
        check("rdw_hist", 256'(hist_count), 2);
        step();
        check("rd_after", 256'(rd_piece), 0);
        rd_addr = 6'd60;
        step();
        check("rd_king", 256'(rd_piece), 6);

        // 6-file board: file 7 rejected, {rank,file} addressing
        m_from = 6'd7; m_to = 6'd0; m_piece = 4'h3; m_move_valid = 1'b1;
        step();
        m_move_valid = 1'b0;
        check("f6_err", 256'(m_cmd_err), 1);
        check("f6_err_hist", 256'(m_hist), 0);
        check("f6_err_board", 256'(m_flat), 0);
        m_from = 6'd0; m_to = 6'd9; m_move_valid = 1'b1;
        step();
        m_move_valid = 1'b0;
        check("f6_sq7", 256'(m_flat[7*4 +: 4]), 3);
        check("f6_hist", 256'(m_hist), 1);
        m_rd_addr = 6'd9;
        step();
        check("f6_rd", 256'(m_rd_piece), 3);
        m_rd_addr = 6'd7;
        step();
        check("f6_rd_oor", 256'(m_rd_piece), 0);

        // Reset during INIT
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        step(); step(); step();
        check("mid_init_sq0", 256'(sq(0)), 256'hC);
        Reset = 1'b1;
        #1;
        check("mid_rst_board", board_flat, '0);
        check("mid_rst_idle", 256'(move_ready), 1);
        check("mid_rst_hist", 256'(hist_count), 0);
        step();
        Reset = 1'b0;
        step();
        check("mid_rst_still0", board_flat, '0);

        // Tick period
        t0 = 0;
        while (!tick && t0 < 5000) begin t0++; step(); end
        t1 = 0;
        step();
        t1 = 1;
        while (!tick && t1 < 5000) begin t1++; step(); end
        check("tick_period", 256'(t1), 4096);
        step();
        check("tick_width", 256'(tick), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
